// File: rtl/binary_time_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : binary_time_counter_if
//  Description : Set requests in, BCD time digits and seconds tick out.
//  Revision    : 1.0
// ============================================================================
interface binary_time_counter_if;
    logic       set_hour;
    logic       set_min;
    logic [1:0] h1;
    logic [3:0] h0;
    logic [2:0] m1;
    logic [3:0] m0;
    logic [2:0] s1;
    logic [3:0] s0;
    logic       tick;

    modport master (
        output set_hour, set_min,
        input  h1, h0, m1, m0, s1, s0, tick
    );

    modport slave (
        input  set_hour, set_min,
        output h1, h0, m1, m0, s1, s0, tick
    );
endinterface
`default_nettype wire

// File: rtl/binary_time_counter.sv
`default_nettype none
// ============================================================================
//  Module      : binary_time_counter
//  Description : 1 Hz prescaler plus 24-hour BCD clock with hour/minute set.
//  Revision    : 1.0
// ============================================================================
module binary_time_counter #(
    parameter int CLK_HZ = 12000000
) (
    input  wire logic              clk,
    input  wire logic              rst,
    binary_time_counter_if.slave   ctr
);
    localparam int                 C_CNT_W  = $clog2(CLK_HZ);
    localparam logic [C_CNT_W-1:0] C_TC_VAL = C_CNT_W'(CLK_HZ - 1);
    localparam logic [C_CNT_W-1:0] C_ONE    = C_CNT_W'(1);

    logic [C_CNT_W-1:0] presc_q, presc_d;
    logic               prev_hour_q, prev_min_q, armed_q;
    logic [1:0]         h1_q, h1_d;
    logic [3:0]         h0_q, h0_d;
    logic [2:0]         m1_q, m1_d;
    logic [3:0]         m0_q, m0_d;
    logic [2:0]         s1_q, s1_d;
    logic [3:0]         s0_q, s0_d;
    logic               tick_q, tick_d;

    logic w_hour_req, w_min_req, w_any_req, w_tc, w_sec_adv;
    logic w_sec_wrap, w_min_wrap, w_hour_wrap, w_sec_carry, w_min_adv, w_hour_adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q     <= '0;
            prev_hour_q <= 1'b0;
            prev_min_q  <= 1'b0;
            armed_q     <= 1'b0;
            h1_q        <= '0;
            h0_q        <= '0;
            m1_q        <= '0;
            m0_q        <= '0;
            s1_q        <= '0;
            s0_q        <= '0;
            tick_q      <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            prev_hour_q <= ctr.set_hour;
            prev_min_q  <= ctr.set_min;
            armed_q     <= 1'b1;
            h1_q        <= h1_d;
            h0_q        <= h0_d;
            m1_q        <= m1_d;
            m0_q        <= m0_d;
            s1_q        <= s1_d;
            s0_q        <= s0_d;
            tick_q      <= tick_d;
        end
    end

    always_comb begin
        // armed_q masks the first edge after reset so a set level held across reset is not taken as a press
        w_hour_req  = armed_q & ctr.set_hour & ~prev_hour_q;
        w_min_req   = armed_q & ctr.set_min  & ~prev_min_q;
        w_any_req   = w_hour_req | w_min_req;
        w_tc        = (presc_q == C_TC_VAL);
        w_sec_adv   = w_tc & ~w_any_req;
        w_sec_wrap  = (s1_q == 3'd5) && (s0_q == 4'd9);
        w_min_wrap  = (m1_q == 3'd5) && (m0_q == 4'd9);
        w_hour_wrap = (h1_q == 2'd2) && (h0_q == 4'd3);
        w_sec_carry = w_sec_adv & w_sec_wrap;
        w_min_adv   = w_sec_carry | w_min_req;
        // A minute request never carries into hours; only a seconds rollover does
        w_hour_adv  = (w_sec_carry & w_min_wrap) | w_hour_req;

        presc_d = (w_any_req || w_tc) ? '0 : presc_q + C_ONE;
        tick_d  = w_sec_adv;
        h1_d = h1_q;
        h0_d = h0_q;
        m1_d = m1_q;
        m0_d = m0_q;
        s1_d = s1_q;
        s0_d = s0_q;

        if (w_any_req) begin
            s1_d = '0;
            s0_d = '0;
        end else if (w_sec_adv) begin
            if (s0_q == 4'd9) begin
                s0_d = '0;
                s1_d = w_sec_wrap ? 3'd0 : s1_q + 3'd1;
            end else begin
                s0_d = s0_q + 4'd1;
            end
        end

        if (w_min_adv) begin
            if (m0_q == 4'd9) begin
                m0_d = '0;
                m1_d = w_min_wrap ? 3'd0 : m1_q + 3'd1;
            end else begin
                m0_d = m0_q + 4'd1;
            end
        end

        if (w_hour_adv) begin
            if (w_hour_wrap) begin
                h1_d = '0;
                h0_d = '0;
            end else if (h0_q == 4'd9) begin
                h0_d = '0;
                h1_d = h1_q + 2'd1;
            end else begin
                h0_d = h0_q + 4'd1;
            end
        end
    end

    assign ctr.h1   = h1_q;
    assign ctr.h0   = h0_q;
    assign ctr.m1   = m1_q;
    assign ctr.m0   = m0_q;
    assign ctr.s1   = s1_q;
    assign ctr.s0   = s0_q;
    assign ctr.tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_binary_time_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_binary_time_counter
//  Description : Directed bench for binary_time_counter with a time-of-day model.
//  Revision    : 1.0
// ============================================================================
module tb_binary_time_counter;
    localparam int CLK_HZ = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    binary_time_counter_if bus ();

    binary_time_counter #(.CLK_HZ(CLK_HZ)) dut (
        .clk (clk),
        .rst (rst),
        .ctr (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: seconds-of-day plus cycle position within the current second
    typedef struct packed {
        logic        armed;
        logic        prev_h;
        logic        prev_m;
        logic        tick;
        logic [31:0] presc;
        logic [16:0] tod;
    } mstate_t;

    mstate_t ms;

    function automatic mstate_t step(mstate_t s, logic sh, logic sm);
        mstate_t n;
        int      tod, h, m;
        logic    hr, mr;
        hr       = s.armed && sh && !s.prev_h;
        mr       = s.armed && sm && !s.prev_m;
        n        = s;
        n.armed  = 1'b1;
        n.prev_h = sh;
        n.prev_m = sm;
        tod      = int'(s.tod);
        if (hr || mr) begin
            h = tod / 3600;
            m = (tod / 60) % 60;
            if (mr) m = (m + 1) % 60;
            if (hr) h = (h + 1) % 24;
            n.tod   = 17'(h * 3600 + m * 60);
            n.presc = '0;
            n.tick  = 1'b0;
        end else if (int'(s.presc) == CLK_HZ - 1) begin
            n.tod   = 17'((tod + 1) % 86400);
            n.presc = '0;
            n.tick  = 1'b1;
        end else begin
            n.presc = s.presc + 32'd1;
            n.tick  = 1'b0;
        end
        return n;
    endfunction

    function automatic logic [19:0] pack(int h, int m, int s);
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) ms <= '0;
        else     ms <= step(ms, bus.set_hour, bus.set_min);
    end

    logic [19:0] w_dut_vec;
    assign w_dut_vec = {bus.h1, bus.h0, bus.m1, bus.m0, bus.s1, bus.s0};

    always @(negedge clk) begin
        int t;
        t = int'(ms.tod);
        n_cmp = n_cmp + 1;
        if (w_dut_vec !== pack(t / 3600, (t / 60) % 60, t % 60) || bus.tick !== ms.tick) begin
            n_fail = n_fail + 1;
            $display("FAIL model_cmp @%0t: got %0d%0d:%0d%0d:%0d%0d tick=%0b, expected %02d:%02d:%02d tick=%0b",
                     $time, bus.h1, bus.h0, bus.m1, bus.m0, bus.s1, bus.s0, bus.tick,
                     t / 3600, (t / 60) % 60, t % 60, ms.tick);
        end
        n_cmp = n_cmp + 1;
        if (bus.h0 > 4'd9 || bus.m0 > 4'd9 || bus.s0 > 4'd9 || bus.m1 > 3'd5 || bus.s1 > 3'd5 ||
            bus.h1 > 2'd2 || (bus.h1 == 2'd2 && bus.h0 > 4'd3)) begin
            n_fail = n_fail + 1;
            $display("FAIL digit_legal @%0t: got %0d%0d:%0d%0d:%0d%0d, required legal BCD time",
                     $time, bus.h1, bus.h0, bus.m1, bus.m0, bus.s1, bus.s0);
        end
    end

    task automatic check_time(input string name, input int h, input int m, input int s, input logic tk);
        n_cmp = n_cmp + 1;
        if (w_dut_vec !== pack(h, m, s) || bus.tick !== tk) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d%0d:%0d%0d:%0d%0d tick=%0b, expected %02d:%02d:%02d tick=%0b",
                     name, bus.h1, bus.h0, bus.m1, bus.m0, bus.s1, bus.s0, bus.tick, h, m, s, tk);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_hour(input int n);
        repeat (n) begin
            bus.set_hour = 1'b1;
            edges(1);
            bus.set_hour = 1'b0;
            edges(1);
        end
    endtask

    task automatic pulse_min(input int n);
        repeat (n) begin
            bus.set_min = 1'b1;
            edges(1);
            bus.set_min = 1'b0;
            edges(1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp        = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.set_hour = 1'b0;
        bus.set_min  = 1'b0;
        edges(2);
        rst = 1'b0;
        check_time("reset_state", 0, 0, 0, 1'b0);

        edges(4);
        check_time("first_tick", 0, 0, 1, 1'b1);
        edges(1);
        check_time("tick_fall", 0, 0, 1, 1'b0);
        edges(3);
        check_time("tick_period", 0, 0, 2, 1'b1);

        edges(57 * CLK_HZ);
        check_time("sec_59", 0, 0, 59, 1'b1);
        edges(CLK_HZ);
        check_time("min_carry", 0, 1, 0, 1'b1);

        pulse_min(58);
        check_time("min_59", 0, 59, 0, 1'b0);
        edges(7);
        check_time("min_59_xx", 0, 59, 2, 1'b1);
        pulse_min(1);
        check_time("set_min_wrap", 0, 0, 0, 1'b0);

        bus.set_hour = 1'b1;
        edges(5);
        bus.set_hour = 1'b0;
        edges(1);
        check_time("hold_hour", 1, 0, 1, 1'b0);
        pulse_hour(22);
        check_time("hour_23", 23, 0, 0, 1'b0);
        pulse_hour(1);
        check_time("hour_wrap", 0, 0, 0, 1'b0);

        pulse_hour(23);
        pulse_min(59);
        check_time("set_2359", 23, 59, 0, 1'b0);
        edges(3 + 58 * CLK_HZ);
        check_time("pre_wrap", 23, 59, 59, 1'b1);
        edges(CLK_HZ);
        check_time("day_wrap", 0, 0, 0, 1'b1);

        edges(3);
        bus.set_min = 1'b1;
        edges(1);
        bus.set_min = 1'b0;
        check_time("collision", 0, 1, 0, 1'b0);
        edges(3);
        check_time("no_early_tick", 0, 1, 0, 1'b0);
        edges(1);
        check_time("collision_next_tick", 0, 1, 1, 1'b1);

        pulse_hour(9);
        pulse_min(58);
        bus.set_hour = 1'b1;
        bus.set_min  = 1'b1;
        edges(1);
        bus.set_hour = 1'b0;
        bus.set_min  = 1'b0;
        check_time("both_0959", 10, 0, 0, 1'b0);
        edges(1);
        pulse_hour(9);
        check_time("h19", 19, 0, 0, 1'b0);
        pulse_hour(1);
        check_time("h19_to_20", 20, 0, 0, 1'b0);

        pulse_hour(16);
        pulse_min(34);
        edges(3 + 55 * CLK_HZ + 2);
        check_time("pre_reset", 12, 34, 56, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_time("async_reset", 0, 0, 0, 1'b0);
        bus.set_hour = 1'b1;
        edges(1);
        rst = 1'b0;
        edges(2);
        bus.set_hour = 1'b0;
        edges(1);
        check_time("post_reset_quiet", 0, 0, 0, 1'b0);
        edges(1);
        check_time("post_reset_tick", 0, 0, 1, 1'b1);
        edges(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
